bcd_countdown_timer: RTL and testbench

//   Multi-digit BCD down-counter (countdown timer); the decrementing counterpart of the BCD up-counters.

---
 rtl/bcd_countdown_timer.sv | 169 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Multi-digit BCD countdown timer. Loads a BCD preset (digits saturated to 9),
//   decrements once every TICK_DIV clocks while running, and flags expiry at zero.
//   With AUTO_RELOAD set, expiry reloads the last preset and keeps running.
//   Per-cycle priority: RES > LOAD > PAUSE > START > tick.

module bcd_countdown_timer #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 50000000,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    input  logic                  START,
    input  logic                  PAUSE,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic                  RUNNING,
    output logic                  DONE,
    output logic                  EXPIRE
);

    localparam int              W          = 4 * DIGITS;
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]    COUNT_ONE  = W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_count;
    logic [W-1:0]    r_preset;
    logic [PW-1:0]   r_presc;
    logic            r_running;
    logic            r_done;
    logic            r_expire;

    logic [W-1:0]    w_load_sat;
    logic [W-1:0]    w_count_dec;
    logic            w_tick;
    logic            w_count_zero;
    logic            w_count_one;
    logic            w_go;

    // Clamp every preset digit above 9 down to 9 so COUNT is always valid BCD
    always_comb begin
        // NOTE: full default before the conditional overrides, so no latch is inferred.
        w_load_sat = LOAD_VAL;
        for (int i = 0; i < DIGITS; i++) begin
            if (LOAD_VAL[4*i +: 4] > 4'd9) begin
                w_load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    // BCD decrement by one: a zero digit becomes 9 and borrows from the next digit,
    // the borrow rippling through all digits in the same cycle
    always_comb begin
        logic borrow;
        w_count_dec = r_count;
        borrow      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_count_zero = (r_count == '0);
    assign w_count_one  = (r_count == COUNT_ONE);
    // PAUSE outranks START, so a START only takes effect with PAUSE low
    assign w_go         = START && !PAUSE;

    // Timer FSM: state, count, preset, prescaler and registered status outputs
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments only, so every register sees pre-edge values.
        if (RES) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_preset  <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expire  <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (LOAD) begin
                r_count   <= w_load_sat;
                r_preset  <= w_load_sat;
                r_presc   <= '0;
                r_state   <= S_IDLE;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_go) begin
                            if (w_count_zero) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_expire <= 1'b1;
                            end else begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                                r_presc   <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (PAUSE) begin
                            // prescaler phase is kept so resume finishes the current period
                            r_state   <= S_PAUSED;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_count_one) begin
                                r_expire <= 1'b1;
                                if (AUTO_RELOAD && (r_preset != '0)) begin
                                    r_count <= r_preset;
                                end else begin
                                    r_count   <= '0;
                                    r_state   <= S_DONE;
                                    r_running <= 1'b0;
                                    r_done    <= 1'b1;
                                end
                            end else begin
                                r_count <= w_count_dec;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (w_go) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        // only LOAD or RES leave DONE
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign COUNT   = r_count;
    assign RUNNING = r_running;
    assign DONE    = r_done;
    assign EXPIRE  = r_expire;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//   Two timers (AUTO_RELOAD 0 and 1, TICK_DIV=4, 4 digits) on shared inputs.
//   Directed vector table, hand-written multi-cycle sequences, then random
//   stimulus compared every cycle against a decimal-integer reference model.

module tb_bcd_countdown_timer;

    localparam int TDIV = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] count_a, count_b;
    logic        running_a, running_b;
    logic        done_a, done_b;
    logic        expire_a, expire_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(TDIV), .AUTO_RELOAD(1'b0)) dut_a (
        .CLK(clk), .RES(res), .LOAD(load), .LOAD_VAL(load_val),
        .START(start), .PAUSE(pause),
        .COUNT(count_a), .RUNNING(running_a), .DONE(done_a), .EXPIRE(expire_a)
    );

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(TDIV), .AUTO_RELOAD(1'b1)) dut_b (
        .CLK(clk), .RES(res), .LOAD(load), .LOAD_VAL(load_val),
        .START(start), .PAUSE(pause),
        .COUNT(count_b), .RUNNING(running_b), .DONE(done_b), .EXPIRE(expire_b)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    typedef struct {
        int value;
        int preset;
        int phase;
        int st;
        bit expire;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, M_IDLE, 1'b0};
    mdl_t mb = '{0, 0, 0, M_IDLE, 1'b0};

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] b = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    function automatic int sat_val(logic [15:0] lv);
        int v = 0;
        int m = 1;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * m;
            m = m * 10;
        end
        return v;
    endfunction

    function automatic mdl_t step(mdl_t s, bit ar, bit r, bit ld, logic [15:0] lv, bit st_in, bit pz);
        mdl_t n = s;
        n.expire = 1'b0;
        if (r) begin
            n = '{0, 0, 0, M_IDLE, 1'b0};
        end else if (ld) begin
            n.value  = sat_val(lv);
            n.preset = n.value;
            n.phase  = 0;
            n.st     = M_IDLE;
        end else begin
            case (s.st)
                M_IDLE: if (st_in && !pz) begin
                    if (s.value == 0) begin
                        n.st = M_DONE;
                        n.expire = 1'b1;
                    end else begin
                        n.st = M_RUN;
                        n.phase = 0;
                    end
                end
                M_RUN: if (pz) begin
                    n.st = M_PAUSED;
                end else begin
                    n.phase = (s.phase + 1) % TDIV;
                    if (n.phase == 0) begin
                        n.value = s.value - 1;
                        if (n.value == 0) begin
                            n.expire = 1'b1;
                            if (ar && s.preset != 0) n.value = s.preset;
                            else n.st = M_DONE;
                        end
                    end
                end
                M_PAUSED: if (st_in && !pz) n.st = M_RUN;
                default: ;
            endcase
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // apply inputs for one edge; sample 1 time unit after that edge
    task automatic cycle(bit r, bit ld, logic [15:0] lv, bit s, bit p);
        res = r; load = ld; load_val = lv; start = s; pause = p;
        @(posedge clk);
        #1;
        ma = step(ma, 1'b0, r, ld, lv, s, p);
        mb = step(mb, 1'b1, r, ld, lv, s, p);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic check_models();
        check("rnd_count_a",   {16'h0, count_a}, {16'h0, to_bcd(ma.value)});
        check("rnd_running_a", running_a, ma.st == M_RUN);
        check("rnd_done_a",    done_a,    ma.st == M_DONE);
        check("rnd_expire_a",  expire_a,  ma.expire);
        check("rnd_count_b",   {16'h0, count_b}, {16'h0, to_bcd(mb.value)});
        check("rnd_running_b", running_b, mb.st == M_RUN);
        check("rnd_done_b",    done_b,    mb.st == M_DONE);
        check("rnd_expire_b",  expire_b,  mb.expire);
    endtask

    // ---------------- directed vector table (dut_a, AUTO_RELOAD=0) ----------------
    typedef struct {
        bit          res;
        bit          load;
        bit          start;
        bit          pause;
        logic [15:0] lv;
        logic [15:0] c;
        bit          r;
        bit          d;
        bit          e;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        int exp_at;
        int mode;
        logic [15:0] lv;

        //          res ld st pz  load_val   count     run dn ex
        vecs[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 16'h1A3F, 16'h1939, 0, 0, 0};  // digit saturation
        vecs[2]  = '{0, 1, 1, 0, 16'h0005, 16'h0005, 0, 0, 0};  // START with LOAD ignored
        vecs[3]  = '{0, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1};  // START at zero -> DONE
        vecs[6]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1, 0};  // DONE ignores START/PAUSE
        vecs[8]  = '{0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0};  // LOAD leaves DONE
        vecs[9]  = '{0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0};  // first tick
        vecs[14] = '{0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1};  // expiry
        vecs[18] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[19] = '{0, 1, 0, 0, 16'h9999, 16'h9999, 0, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].res, vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].pause);
            check($sformatf("vec%0d_count", i),   {16'h0, count_a}, {16'h0, vecs[i].c});
            check($sformatf("vec%0d_running", i), running_a, vecs[i].r);
            check($sformatf("vec%0d_done", i),    done_a,    vecs[i].d);
            check($sformatf("vec%0d_expire", i),  expire_a,  vecs[i].e);
        end

        // ---- 0102 countdown with multi-digit borrow, expiry at 408 clocks ----
        cycle(1'b0, 1'b1, 16'h0102, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        exp_at = -1;
        for (int k = 1; k <= 420; k++) begin
            idle_cycle();
            if (k == 4)   check("t2_k4",  {16'h0, count_a}, 32'h0101);
            if (k == 8)   check("t2_k8",  {16'h0, count_a}, 32'h0100);
            if (k == 12)  check("t2_k12", {16'h0, count_a}, 32'h0099);
            if (k == 408) check("t2_zero", {16'h0, count_a}, 32'h0000);
            if (k == 409) begin
                check("t2_expire_one_cycle", expire_a, 1'b0);
                check("t2_done_held", done_a, 1'b1);
            end
            if (expire_a && exp_at < 0) exp_at = k;
        end
        check("t2_expire_cycle", exp_at, 408);

        // ---- pause mid-period, hold, resume at held phase ----
        cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (6) idle_cycle();
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("t4_paused_running", running_a, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 16'h0000, (k == 10), 1'b1);  // START with PAUSE high stays paused
            check($sformatf("t4_hold%0d", k), {16'h0, count_a}, 32'h0009);
        end
        check("t4_still_paused", running_a, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t4_resume_running", running_a, 1'b1);
        idle_cycle();
        check("t4_resume_k1", {16'h0, count_a}, 32'h0009);
        idle_cycle();
        check("t4_resume_k2", {16'h0, count_a}, 32'h0008);

        // ---- reset held 2 cycles mid-run ----
        cycle(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (10) idle_cycle();
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t1_count",   {16'h0, count_a}, 32'h0000);
        check("t1_running", running_a, 1'b0);
        check("t1_done",    done_a,    1'b0);
        check("t1_expire",  expire_a,  1'b0);

        // ---- auto-reload (dut_b): 2,1,2,1... expiry every 8 clocks ----
        cycle(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            idle_cycle();
            check($sformatf("t5_count%0d", k), {16'h0, count_b},
                  (((k / 4) % 2) == 1) ? 32'h0001 : 32'h0002);
            check($sformatf("t5_expire%0d", k), expire_b, (k % 8) == 0);
            check($sformatf("t5_done%0d", k), done_b, 1'b0);
        end

        // ---- random stimulus against the reference model ----
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_models();
        for (int n = 0; n < 3000; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       lv = 16'($urandom);
                1:       lv = to_bcd(int'($urandom_range(0, 3)));
                2:       lv = to_bcd(int'($urandom_range(0, 20)));
                default: lv = to_bcd(int'($urandom_range(0, 9999)));
            endcase
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 15) == 0,
                  lv,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0);
            check_models();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
